ad7324_emu_slave: RTL

//  SPI responder that emulates the AD7324 ADC on the converter-side header, so the closed-loop

---
 rtl/ad7324_emu_slave.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ad7324_emu_slave.sv
// ad7324_emu_slave: SPI responder standing in for an AD7324 ADC.
// Oversamples CS_N/SCLK/DIN on the system clock, accepts control-register
// writes on DIN and returns {0, CH_ID, DATA} words on DOUT with the
// one-frame channel latency of the real part.
// Optional feature macro: ADC_EMU_CODING_EN (honour the CODING bit, CTRL_REG[5]).
module ad7324_emu_slave #(
    parameter int          SYNC_STAGES = 2,
    parameter int          FRAME_BITS  = 16,
    parameter logic [12:0] CTRL_RST    = 13'h0
) (
    input  logic        i_clk,
    input  logic        i_rstp,
    input  logic        i_cs_n,
    input  logic        i_sclk,
    input  logic        i_din,
    output logic        o_dout,
    output logic        o_dout_oe,
    input  logic [12:0] i_ch0,
    input  logic [12:0] i_ch1,
    input  logic [12:0] i_ch2,
    input  logic [12:0] i_ch3,
    output logic [12:0] o_ctrl_reg,
    output logic [1:0]  o_cur_ch,
    output logic        o_frame_done,
    output logic        o_frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t             r_state, w_stateNext;
    logic [SYNC_STAGES-1:0] r_csSync, r_sclkSync, r_dinSync;
    logic               r_csPrev, r_sclkPrev;
    logic [15:0]        r_tx, w_txNext;
    logic [15:0]        r_rx, w_rxNext;
    logic [CNT_W-1:0]   r_bitCnt, w_bitCntNext;
    logic               r_dout, w_doutNext;
    logic               r_doutOe, w_doutOeNext;
    logic [12:0]        r_ctrl, w_ctrlNext;
    logic [1:0]         r_curCh, w_curChNext;
    logic               r_frameValid, w_frameValidNext;
    logic               r_frameDone, w_frameDoneNext;
    logic               r_frameErr, w_frameErrNext;

    logic               w_cs, w_sclk, w_din;
    logic               w_csFall, w_csRise, w_sclkFall;
    logic [12:0]        w_sample, w_data;
    logic               w_isCtrlWrite;

    // Bring the asynchronous SPI pins into the clock domain; idle levels on reset
    always_ff @(posedge i_clk or posedge i_rstp) begin
        if (i_rstp) begin
            r_csSync   <= '1;
            r_sclkSync <= '1;
            r_dinSync  <= '0;
            r_csPrev   <= 1'b1;
            r_sclkPrev <= 1'b1;
        end else begin
            r_csSync   <= {r_csSync[SYNC_STAGES-2:0], i_cs_n};
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], i_sclk};
            r_dinSync  <= {r_dinSync[SYNC_STAGES-2:0], i_din};
            r_csPrev   <= w_cs;
            r_sclkPrev <= w_sclk;
        end
    end

    assign w_cs       = r_csSync[SYNC_STAGES-1];
    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_din      = r_dinSync[SYNC_STAGES-1];
    assign w_csFall   = r_csPrev & ~w_cs;
    assign w_csRise   = ~r_csPrev & w_cs;
    assign w_sclkFall = r_sclkPrev & ~w_sclk;

    // Pick the sample for the current channel and apply the output coding
    always_comb begin
        w_sample = i_ch0;
        case (r_curCh)
            2'd0: w_sample = i_ch0;
            2'd1: w_sample = i_ch1;
            2'd2: w_sample = i_ch2;
            2'd3: w_sample = i_ch3;
            default: w_sample = i_ch0;
        endcase
`ifdef ADC_EMU_CODING_EN
        w_data = r_ctrl[5] ? {~w_sample[12], w_sample[11:0]} : w_sample;
`else
        w_data = w_sample;
`endif
    end

    assign w_isCtrlWrite = r_rx[15] & (r_rx[14:13] == 2'b00);

    // Frame sequencing: next state plus every datapath update it implies
    always_comb begin
        w_stateNext      = r_state;
        w_txNext         = r_tx;
        w_rxNext         = r_rx;
        w_bitCntNext     = r_bitCnt;
        w_doutNext       = r_dout;
        w_doutOeNext     = r_doutOe;
        w_ctrlNext       = r_ctrl;
        w_curChNext      = r_curCh;
        w_frameValidNext = r_frameValid;
        w_frameDoneNext  = 1'b0;
        w_frameErrNext   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_csFall) begin
                    w_txNext     = {1'b0, r_curCh, w_data};
                    w_rxNext     = '0;
                    w_doutNext   = 1'b0;
                    w_doutOeNext = 1'b1;
                    w_bitCntNext = '0;
                    w_stateNext  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_csRise) begin
                    w_doutOeNext     = 1'b0;
                    w_doutNext       = 1'b0;
                    w_frameValidNext = (r_bitCnt >= CNT_W'(FRAME_BITS));
                    w_frameErrNext   = (r_bitCnt < CNT_W'(FRAME_BITS));
                    w_stateNext      = S_DONE;
                end else if (w_sclkFall) begin
                    if (r_bitCnt < CNT_W'(FRAME_BITS)) begin
                        w_rxNext     = {r_rx[14:0], w_din};
                        w_txNext     = {r_tx[14:0], 1'b0};
                        w_doutNext   = r_tx[14];
                        w_bitCntNext = r_bitCnt + CNT_W'(1);
                    end else begin
                        w_doutNext = 1'b0;
                    end
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
                if (r_frameValid) begin
                    w_frameDoneNext = 1'b1;
                    if (w_isCtrlWrite) begin
                        w_ctrlNext  = r_rx[12:0];
                        w_curChNext = r_rx[11:10];
                    end else if (r_ctrl[3]) begin
                        w_curChNext = (r_curCh == r_ctrl[11:10]) ? 2'd0 : r_curCh + 2'd1;
                    end else begin
                        w_curChNext = r_ctrl[11:10];
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rstp) begin
        if (i_rstp) r_state <= S_IDLE;
        else        r_state <= w_stateNext;
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or posedge i_rstp) begin
        if (i_rstp) begin
            r_tx         <= '0;
            r_rx         <= '0;
            r_bitCnt     <= '0;
            r_dout       <= 1'b0;
            r_doutOe     <= 1'b0;
            r_ctrl       <= CTRL_RST;
            r_curCh      <= 2'd0;
            r_frameValid <= 1'b0;
            r_frameDone  <= 1'b0;
            r_frameErr   <= 1'b0;
        end else begin
            r_tx         <= w_txNext;
            r_rx         <= w_rxNext;
            r_bitCnt     <= w_bitCntNext;
            r_dout       <= w_doutNext;
            r_doutOe     <= w_doutOeNext;
            r_ctrl       <= w_ctrlNext;
            r_curCh      <= w_curChNext;
            r_frameValid <= w_frameValidNext;
            r_frameDone  <= w_frameDoneNext;
            r_frameErr   <= w_frameErrNext;
        end
    end

    assign o_dout       = r_dout;
    assign o_dout_oe    = r_doutOe;
    assign o_ctrl_reg   = r_ctrl;
    assign o_cur_ch     = r_curCh;
    assign o_frame_done = r_frameDone;
    assign o_frame_err  = r_frameErr;

endmodule
